// File: rtl/sine_generator.sv
// sine_generator: free-running DDS tone source for the transmit DAC.
// Phase accumulator -> quadrant/index register -> quarter-wave ROM lookup
// folded into a full offset-binary sine, registered onto the DAC bus.
module sine_generator #(
  parameter int                 PHASE_W = 32,
  parameter logic [PHASE_W-1:0] FTW     = PHASE_W'(349525333),
  parameter int                 OUT_W   = 14
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] dac_output
);

  localparam int ROM_AW = 8;
  localparam int ROM_DW = 13;
  localparam int ROM_N  = 2 ** ROM_AW;
  localparam logic [OUT_W-1:0] MID_HI = OUT_W'(8192);
  localparam logic [OUT_W-1:0] MID_LO = OUT_W'(8191);
  // pi/2 in Q30 fixed point
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  // Quarter-wave table entry: round(8191 * sin(pi/2 * (idx + 0.5) / 256)).
  // Evaluated at elaboration with a Q30 Taylor series; the half-step offset
  // keeps the folded waveform symmetric about 8191.5.
  function automatic logic [ROM_DW-1:0] sine_round(input int idx);
    longint x;
    longint x2;
    longint term;
    longint s;
    longint scaled;
    x    = (HALF_PI_Q30 * longint'(2 * idx + 1)) / 64'sd512;
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    scaled = (64'sd8191 * s + (64'sd1 <<< 29)) >>> 30;
    return ROM_DW'(scaled);
  endfunction

  // Fold a quarter-wave magnitude into the full offset-binary range.
  // Upper half sits above 8192, lower half mirrors below 8191; the sum is
  // formed at full output width so the carry into the MSB is kept.
  function automatic logic [OUT_W-1:0] quad_map(input logic [1:0]        quad,
                                                input logic [ROM_DW-1:0] mag);
    if (!quad[1]) begin
      return MID_HI + OUT_W'(mag);
    end
    return MID_LO - OUT_W'(mag);
  endfunction

  logic [PHASE_W-1:0] acc_p0;
  logic [ROM_AW+1:0]  addr_p1;
  logic               vld_p1;
  logic [ROM_AW-1:0]  rom_idx;
  logic [ROM_DW-1:0]  rom_data;
  logic [ROM_DW-1:0]  rom [ROM_N];

  for (genvar i = 0; i < ROM_N; i++) begin : g_rom
    localparam logic [ROM_DW-1:0] ROM_VAL = sine_round(i);
    assign rom[i] = ROM_VAL;
  end

  // ---- stage 0: phase accumulator ----
  // Advance phase by the tuning word every clock; wraps by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p0 <= '0;
    end else begin
      acc_p0 <= acc_p0 + FTW;
    end
  end

  // ---- stage 1: quadrant + index register ----
  // Latch the top phase bits; valid rises on the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      addr_p1 <= acc_p0[PHASE_W-1 -: ROM_AW+2];
      vld_p1  <= 1'b1;
    end
  end

  // Odd quadrants read the table backwards (255 - k is the bitwise inverse).
  assign rom_idx  = addr_p1[ROM_AW] ? ~addr_p1[ROM_AW-1:0] : addr_p1[ROM_AW-1:0];
  assign rom_data = rom[rom_idx];

  // ---- stage 2: DAC output register ----
  // Hold midscale until stage 1 carries a real phase, then emit samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac_output <= MID_HI;
    end else if (vld_p1) begin
      dac_output <= quad_map(addr_p1[ROM_AW+1:ROM_AW], rom_data);
    end else begin
      dac_output <= MID_HI;
    end
  end

endmodule

// File: tb/tb_sine_generator.sv
// tb_sine_generator: several DDS instances with different tuning words share
// clock and reset; a reference model queues the expected sample per edge and a
// monitor compares on the falling edge. Reset pulses are placed randomly.
`timescale 1ns/1ps
module tb_sine_generator;

  localparam int  NI = 6;
  localparam real PI = 3.141592653589793;
  localparam logic [31:0] FTWS [NI] = '{32'd349525333, 32'h4000_0000, 32'h0040_0000,
                                        32'hFFC0_0000, 32'h0000_0000, 32'h9E37_79B9};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] dac [NI];

  int wave [1024];
  int exp_q [NI][$];
  int e = 0;
  int n_cmp = 0;
  int n_err = 0;
  int sweep [1024];
  int tone [130];

  always #4.069 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sine_generator #(.PHASE_W(32), .FTW(FTWS[g]), .OUT_W(14)) u_dut (
      .clk(clk),
      .rst(rst),
      .dac_output(dac[g])
    );
  end

  function automatic void check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  // Expected DAC value after 'edges' rising edges with reset released.
  function automatic int expected(input int g, input int edges);
    logic [31:0] ph;
    if (edges <= 1) return 8192;
    ph = FTWS[g] * 32'(edges - 2);
    return wave[ph[31:22]];
  endfunction

  // Reference model: count edges since release and queue the expected sample.
  always @(negedge rst) e = 0;
  always @(posedge clk) begin
    if (rst) e = e + 1;
    else e = 0;
    for (int g = 0; g < NI; g++) exp_q[g].push_back(expected(g, e));
  end

  // Monitor: compare every instance on the falling edge.
  always @(negedge clk) begin
    int w;
    for (int g = 0; g < NI; g++) begin
      if (exp_q[g].size() > 0) begin
        w = exp_q[g].pop_front();
        check($sformatf("dds%0d_sample", g), int'(dac[g]), w);
      end
    end
  end

  task automatic check_all_mid(input string name);
    for (int g = 0; g < NI; g++) check($sformatf("%s_dds%0d", name, g), int'(dac[g]), 8192);
  endtask

  initial begin
    int run;
    int hold;
    int mx;
    int mn;
    int nbad;
    int last;
    int ncross;
    int iv;
    real s;

    // Full-wave reference: offset-binary sine sampled at half-step phase offsets.
    for (int p = 0; p < 1024; p++) begin
      s = $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
      if (p < 512) wave[p] = 8192 + int'($floor(8191.0 * s + 0.5));
      else         wave[p] = 8191 - int'($floor(-8191.0 * s + 0.5));
    end

    // Power-up reset, held a few cycles.
    #1 rst = 1'b0;
    #0.5 check_all_mid("rst_async_init");
    repeat (3) @(negedge clk);
    #4 rst = 1'b1;

    // Random run lengths with random async reset pulses / holds.
    for (int it = 0; it < 5; it++) begin
      run = $urandom_range(40, 300);
      repeat (run) @(negedge clk);
      #1 rst = 1'b0;
      #0.5 check_all_mid("rst_async_mid");
      hold = $urandom_range(0, 4);
      if (hold == 0) begin
        #2.5 rst = 1'b1;
      end else begin
        repeat (hold) @(negedge clk);
        #1 check_all_mid("rst_held");
        #3 rst = 1'b1;
      end
    end

    // Final restart with a 3 ns pulse, then capture for waveform properties.
    @(negedge clk);
    #1 rst = 1'b0;
    #0.5 check_all_mid("rst_pulse_final");
    #2.5 rst = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1;
      if (c >= 2) begin
        if (c - 2 < 1024) sweep[c-2] = int'(dac[2]);
        if (c - 2 < 130)  tone[c-2]  = int'(dac[0]);
      end
    end

    // One ROM step per clock: full swing, odd symmetry, rising first quarter.
    mx = 0;
    mn = 16383;
    for (int j = 0; j < 1024; j++) begin
      if (sweep[j] > mx) mx = sweep[j];
      if (sweep[j] < mn) mn = sweep[j];
    end
    check("sweep_max", mx, 16383);
    check("sweep_min", mn, 0);
    nbad = 0;
    for (int j = 0; j < 512; j++) if (sweep[j] + sweep[j+512] != 16383) nbad++;
    check("sweep_symmetry_violations", nbad, 0);
    nbad = 0;
    for (int j = 0; j < 255; j++) if (sweep[j+1] < sweep[j]) nbad++;
    check("sweep_monotonic_violations", nbad, 0);

    // Default tone over ~1000 ns: midscale upward crossings every 12-13 clocks.
    last = -1;
    ncross = 0;
    for (int j = 1; j < 123; j++) begin
      if (tone[j-1] < 8192 && tone[j] >= 8192) begin
        if (last >= 0) begin
          iv = j - last;
          n_cmp++;
          if (iv < 12 || iv > 13) begin
            n_err++;
            $display("FAIL tone_period got %0d clocks expected 12..13", iv);
          end
        end
        last = j;
        ncross++;
      end
    end
    n_cmp++;
    if (ncross < 9) begin
      n_err++;
      $display("FAIL tone_crossings got %0d expected at least 9", ncross);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sine_generator.md
Name: sine_generator

Overview:
- Free-running DDS sine source for the HFSWR transmit chain; drives the 14-bit DAC sample bus every clock.
- Phase accumulator, quarter-wave sine ROM and output register.
- Tone frequency is fixed per build by parameter; there are no control inputs beyond clock and reset.
- Nominal clock is 122.88 MHz (8.138 ns period).

Parameters:
- PHASE_W, 32, phase accumulator width in bits.
- FTW, 349525333, frequency tuning word added each clock. Default gives ~10 MHz at 122.88 MHz; f_out = FTW * f_clk / 2^PHASE_W.
- OUT_W, 14, DAC sample width. Fixed at 14; the ROM contents are sized for it.

Ports:
- clk  input  1  sample clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
- dac_output  output  14  DAC sample, offset-binary unsigned. Midscale is 8192, range 0..16383.

Behaviour:
- Reset (rst=0): the following are cleared immediately, without a clock:
  - acc (PHASE_W-bit phase accumulator) = 0
  - addr_q (stage-1 register: quadrant + index) = 0
  - stage-1 valid flag = 0
  - dac_output = 8192
- Reset is held for as long as rst=0. Reset asserted mid-operation returns all state to these values at once.
- Accumulator: on every rising edge out of reset, acc <= acc + FTW, modulo 2^PHASE_W. Wrap-around is natural overflow with no special handling.
- Phase to address:
  - p = acc[PHASE_W-1 : PHASE_W-10], a 10-bit phase.
  - quad = p[9:8], k = p[7:0].
  - Stage-1 register on each edge: addr_q <= {quad, k} taken from the current acc. The valid flag is set on the same edge.
- Quarter-wave ROM: 256 entries, 13-bit.
  - Q[i] = round(8191 * sin(pi/2 * (i + 0.5) / 256)), i = 0..255.
  - The half-LSB phase offset makes the waveform exactly symmetric about 8191.5.
  - Required values: Q[0] = 25, Q[255] = 8191.
  - Implement as a case-statement ROM or an initialised array.
- Quadrant mapping (stage 2, registered into dac_output):
  - quad 0: 8192 + Q[k]
  - quad 1: 8192 + Q[255-k]
  - quad 2: 8191 - Q[k]
  - quad 3: 8191 - Q[255-k]
  - The results always fit in 14 bits (0..16383). No saturation logic is needed, but the arithmetic must be done at 14 bits with no truncation of the carry into bit 13.
- Stage-2 gating: while the stage-1 valid flag is 0 (only the first edge after reset release), dac_output keeps 8192.
- Latency:
  - Edge 1 after rst release: acc goes 0 -> FTW; phase 0 is latched into stage 1.
  - Edge 2: dac_output = sample(phase 0).
  - Edge n (n >= 2): dac_output = sample(phase (n-2)*FTW).
  - One new sample per clock; 2-cycle latency from accumulator value to output.
- No gaps or stalls; output is continuous.
- FTW = 0 gives a constant output of 8217 (quad 0, k 0).
- FTW >= 2^(PHASE_W-1) aliases; this is legal and produces no special behaviour.

Test Plan:
- Reset value:
  - Stimulus: rst=0 asynchronously mid-cycle while running.
  - Required: dac_output = 8192 immediately, before the next clk edge. It stays at 8192 while rst=0 and for the first edge after release.
- Quadrant sequence:
  - Stimulus: override FTW = 2^30, release reset.
  - Required: from edge 2 on, dac_output repeats 8217, 16383, 8166, 0.
- Symmetry/extremes:
  - Stimulus: FTW = 2^22 (one ROM step per clock), run 1024 clocks.
  - Required:
    - max = 16383, min = 0.
    - sample[j] + sample[j+512] = 16383 for all j.
    - Output is monotonic non-decreasing over j = 0..255.
- Default tone:
  - Stimulus: default FTW, run 1000 ns at an 8.138 ns period.
  - Required:
    - Period ≈ 12.288 clocks, i.e. midscale upward crossings about every 12-13 clocks.
    - All values stay within 0..16383.
- Accumulator wrap:
  - Stimulus: FTW = 2^32 - 2^22 (negative step).
  - Required: the output traverses the ROM in reverse. The first samples are 8217, then 8166 (quad 3, k 255, = 8191 - Q[0]), with no glitch at the wrap.
- Reset mid-operation:
  - Stimulus: pulse rst low for 3 ns between edges, then release.
  - Required: the sequence restarts exactly as after the initial reset (8192, then sample(phase 0) on edge 2).
